// File: rtl/gray_pos_decoder.sv
// gray_pos_decoder
// Converts Gray-coded absolute encoder samples to binary positions and checks
// that each new sample is a plausible step away from the last accepted
// position, using modular arithmetic so the position may wrap. The pipeline
// has three register stages: capture, Gray-to-binary, and plausibility/state.
//
// Optional feature: define GRAY_POS_DELTA_EN to add the delta_out port, which
// carries the signed delta of every processed sample.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   in_valid   one-cycle sample strobe (may be asserted every cycle)
//   gray_in    Gray-coded position, sampled with in_valid
//   err_clr    synchronous clear of err_cnt
//   data_out   last accepted binary position
//   out_valid  pulse: a sample was processed (accepted or rejected)
//   jump_err   pulse with out_valid: sample rejected
//   resync     pulse with out_valid: sample force-accepted after rejections
//   err_cnt    saturating count of rejected samples
//   delta_out  signed delta of the processed sample (GRAY_POS_DELTA_EN only)
module gray_pos_decoder #(
    parameter int unsigned WIDTH        = 25,
    parameter int unsigned MAX_STEP     = 16,
    parameter int unsigned REJECT_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             jump_err,
    output logic             resync,
    output logic [7:0]       err_cnt
`ifdef GRAY_POS_DELTA_EN
    ,
    output logic [WIDTH-1:0] delta_out
`endif
);

    localparam logic [WIDTH-1:0] MaxStep  = WIDTH'(MAX_STEP);
    localparam logic [3:0]       RejLimit = 4'(REJECT_LIMIT);

    typedef enum logic [1:0] {StInit, StTrack, StResync} state_e;

    state_e           state_q;
    logic [3:0]       rej_cnt_q;
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_gray_q;
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] delta;
    logic [WIDTH-1:0] delta_mag;
    logic             in_range;
    logic             reject_now;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            bin_d[i] = ^(s1_gray_q >> i);
        end
    end

    // Modular difference read as signed; the most negative value negates to
    // itself, whose unsigned magnitude 2^(WIDTH-1) always exceeds MaxStep.
    always_comb begin
        delta      = s2_bin_q - data_out;
        delta_mag  = delta[WIDTH-1] ? (~delta + 1'b1) : delta;
        in_range   = (delta_mag <= MaxStep);
        reject_now = s2_valid_q && (state_q == StTrack) && !in_range;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_gray_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_bin_q   <= '0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_gray_q <= gray_in;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_bin_q <= bin_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StInit;
            rej_cnt_q <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            jump_err  <= 1'b0;
            resync    <= 1'b0;
`ifdef GRAY_POS_DELTA_EN
            delta_out <= '0;
`endif
        end else begin
            out_valid <= s2_valid_q;
            jump_err  <= 1'b0;
            resync    <= 1'b0;
            if (s2_valid_q) begin
`ifdef GRAY_POS_DELTA_EN
                delta_out <= delta;
`endif
                unique case (state_q)
                    StInit: begin
                        data_out  <= s2_bin_q;
                        rej_cnt_q <= '0;
                        state_q   <= StTrack;
                    end
                    StTrack: begin
                        if (in_range) begin
                            data_out  <= s2_bin_q;
                            rej_cnt_q <= '0;
                        end else begin
                            jump_err  <= 1'b1;
                            rej_cnt_q <= rej_cnt_q + 4'd1;
                            if (rej_cnt_q + 4'd1 == RejLimit) begin
                                state_q <= StResync;
                            end
                        end
                    end
                    StResync: begin
                        data_out  <= s2_bin_q;
                        resync    <= 1'b1;
                        rej_cnt_q <= '0;
                        state_q   <= StTrack;
                    end
                    default: state_q <= StInit;
                endcase
            end
        end
    end

    // Updates on the same edge that raises jump_err, so a clear landing on
    // that edge leaves a count of one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= reject_now ? 8'd1 : 8'd0;
        end else if (reject_now && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_gray_pos_decoder.sv
module tb_gray_pos_decoder;

    localparam int W = 25;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] gray_in = '0;
    logic         err_clr = 1'b0;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         jump_err;
    logic         resync;
    logic [7:0]   err_cnt;
`ifdef GRAY_POS_DELTA_EN
    logic [W-1:0] delta_out;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    gray_pos_decoder #(
        .WIDTH        (W),
        .MAX_STEP     (16),
        .REJECT_LIMIT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .gray_in   (gray_in),
        .err_clr   (err_clr),
        .data_out  (data_out),
        .out_valid (out_valid),
        .jump_err  (jump_err),
        .resync    (resync),
        .err_cnt   (err_cnt)
`ifdef GRAY_POS_DELTA_EN
        ,
        .delta_out (delta_out)
`endif
    );

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one sample (binary position, Gray-encoded here) and wait, bounded,
    // for its out_valid. lat counts rising edges from the capture edge.
    task automatic send_wait(input logic [W-1:0] pos, output logic got,
                             output int lat, output logic [W-1:0] dout,
                             output logic je, output logic rs,
                             output logic [W-1:0] dl);
        @(negedge clk);
        in_valid = 1'b1;
        gray_in  = to_gray(pos);
        @(negedge clk);
        in_valid = 1'b0;
        lat  = 1;
        got  = 1'b0;
        dout = '0;
        je   = 1'b0;
        rs   = 1'b0;
        dl   = '0;
        while (!got && lat < 8) begin
            if (out_valid) begin
                got  = 1'b1;
                dout = data_out;
                je   = jump_err;
                rs   = resync;
`ifdef GRAY_POS_DELTA_EN
                dl   = delta_out;
`endif
            end else begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        logic got, je, rs;
        int lat;
        logic [W-1:0] d, dl;
        do_reset();
        n_vec++;
        if ({data_out, out_valid, jump_err, resync, err_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got data=%0d ov=%0b je=%0b rs=%0b cnt=%0d, want all 0",
                     data_out, out_valid, jump_err, resync, err_cnt);
        end
        // gray 0x7 -> binary 5
        @(negedge clk);
        in_valid = 1'b1;
        gray_in  = 25'h0000007;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat < 8) begin
            if (out_valid) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        d = data_out; je = jump_err; rs = resync; dl = '0;
        n_vec++;
        if (!got || lat !== 3) begin
            n_err++;
            $display("FAIL first_latency: got=%0b latency=%0d, want 1 and 3", got, lat);
        end
        n_vec++;
        if (d !== 25'd5 || je !== 1'b0 || rs !== 1'b0) begin
            n_err++;
            $display("FAIL first_sample: data=%0d je=%0b rs=%0b, want 5 0 0", d, je, rs);
        end
    endtask

    task automatic test_wrap();
        logic got, je, rs;
        int lat;
        logic [W-1:0] d, dl;
        do_reset();
        send_wait(25'h1FFFFFF, got, lat, d, je, rs, dl);
        n_vec++;
        if (!got || d !== 25'h1FFFFFF || je !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_top: got=%0b data=%h je=%0b, want 1 1ffffff 0", got, d, je);
        end
        send_wait(25'h0, got, lat, d, je, rs, dl);
        n_vec++;
        if (!got || d !== 25'h0 || je !== 1'b0 || rs !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_zero: got=%0b data=%h je=%0b rs=%0b, want 1 0 0 0", got, d, je, rs);
        end
`ifdef GRAY_POS_DELTA_EN
        n_vec++;
        if (dl !== 25'd1) begin
            n_err++;
            $display("FAIL wrap_delta: delta=%h, want 1", dl);
        end
`endif
    endtask

    task automatic test_reject();
        logic got, je, rs;
        int lat;
        logic [W-1:0] d, dl;
        do_reset();
        send_wait(25'd100, got, lat, d, je, rs, dl);
        send_wait(25'd200, got, lat, d, je, rs, dl);
        n_vec++;
        if (!got || je !== 1'b1 || d !== 25'd100 || err_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL reject: got=%0b je=%0b data=%0d cnt=%0d, want 1 1 100 1",
                     got, je, d, err_cnt);
        end
`ifdef GRAY_POS_DELTA_EN
        n_vec++;
        if (dl !== 25'd100) begin
            n_err++;
            $display("FAIL reject_delta: delta=%0d, want 100", dl);
        end
`endif
    endtask

    task automatic test_resync();
        logic got, je, rs;
        int lat;
        logic [W-1:0] d, dl;
        do_reset();
        send_wait(25'd100, got, lat, d, je, rs, dl);
        for (int i = 0; i < 3; i++) begin
            send_wait(25'd200, got, lat, d, je, rs, dl);
            n_vec++;
            if (!got || je !== 1'b1 || rs !== 1'b0 || d !== 25'd100) begin
                n_err++;
                $display("FAIL resync_reject%0d: got=%0b je=%0b rs=%0b data=%0d, want 1 1 0 100",
                         i, got, je, rs, d);
            end
        end
        send_wait(25'd200, got, lat, d, je, rs, dl);
        n_vec++;
        if (!got || je !== 1'b0 || rs !== 1'b1 || d !== 25'd200 || err_cnt !== 8'd3) begin
            n_err++;
            $display("FAIL resync_accept: got=%0b je=%0b rs=%0b data=%0d cnt=%0d, want 1 0 1 200 3",
                     got, je, rs, d, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        do_reset();
        // Sample k driven at step k appears at step k+3.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k >= 3 && k < 11) begin
                if (out_valid !== 1'b1 || data_out !== W'(k - 3) || jump_err !== 1'b0
                    || resync !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_step%0d: ov=%0b data=%0d je=%0b rs=%0b, want 1 %0d 0 0",
                             k, out_valid, data_out, jump_err, resync, k - 3);
                end
            end else if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL b2b_idle%0d: ov=%0b, want 0", k, out_valid);
            end
            in_valid = (k < 8);
            gray_in  = to_gray(W'(k));
        end
        in_valid = 1'b0;
        n_vec++;
        if (bad != 0) n_err++;
        n_vec++;
        if (err_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL b2b_errcnt: cnt=%0d, want 0", err_cnt);
        end
    endtask

    task automatic test_saturation();
        logic got, je, rs;
        int lat;
        int rejects = 0;
        logic [W-1:0] d, dl;
        do_reset();
        send_wait(25'd100, got, lat, d, je, rs, dl);
        // Each group of four far samples gives three rejects and one resync.
        for (int g = 0; g < 86; g++) begin
            for (int i = 0; i < 4; i++) begin
                send_wait((g % 2 == 0) ? 25'd200 : 25'd100, got, lat, d, je, rs, dl);
                if (je === 1'b1) rejects++;
            end
        end
        n_vec++;
        if (rejects != 258) begin
            n_err++;
            $display("FAIL sat_rejects: counted=%0d, want 258", rejects);
        end
        n_vec++;
        if (err_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL sat_hold: cnt=%0d, want 255", err_cnt);
        end
        // Position is now 100 in tracking; 200 rejects while err_clr lands on
        // the same edge.
        @(negedge clk);
        in_valid = 1'b1;
        gray_in  = to_gray(25'd200);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || jump_err !== 1'b1 || err_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL clr_with_err: ov=%0b je=%0b cnt=%0d, want 1 1 1",
                     out_valid, jump_err, err_cnt);
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_vec++;
        if (err_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL clr_plain: cnt=%0d, want 0", err_cnt);
        end
    endtask

    task automatic test_reset_inflight();
        logic got, je, rs;
        int lat;
        int seen = 0;
        logic [W-1:0] d, dl;
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        gray_in  = to_gray(25'd40);
        @(negedge clk);
        gray_in  = to_gray(25'd41);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL inflight_flush: out_valid cycles=%0d, want 0", seen);
        end
        // Far from the flushed samples, so only INIT handling accepts it.
        send_wait(25'd3000, got, lat, d, je, rs, dl);
        n_vec++;
        if (!got || d !== 25'd3000 || je !== 1'b0 || rs !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_init: got=%0b data=%0d je=%0b rs=%0b, want 1 3000 0 0",
                     got, d, je, rs);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_reject();
        test_resync();
        test_back_to_back();
        test_saturation();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
